// File: rtl/bit_serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: Diff = A - B - BorrowI, one bit per clock.
// Optional two's-complement Overflow output enabled by BIT_SERIAL_SUBTRACTOR_OVF_EN.
module bit_serial_subtractor #(
  parameter int unsigned WIDTH = 15,
  parameter int unsigned CNT_W = 5
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BorrowI,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Diff,
  output logic             BorrowO
`ifdef BIT_SERIAL_SUBTRACTOR_OVF_EN
  ,
  output logic             Overflow
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, nextState;

  logic [WIDTH-1:0] sa, sb;
  // Upper WIDTH-1 result bits; the final d completes the word on the exit edge.
  logic [WIDTH-2:0] res;
  logic             br;
  logic [CNT_W-1:0] cnt;
  logic             d, brNext, lastBit;

`ifdef BIT_SERIAL_SUBTRACTOR_OVF_EN
  logic aMsb, bMsb;
`endif

  assign d       = sa[0] ^ sb[0] ^ br;
  assign brNext  = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
  assign lastBit = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    Busy      = 1'b0;
    Done      = 1'b0;
    case (state)
      IDLE: if (Start) nextState = RUN;
      RUN: begin
        Busy = 1'b1;
        if (lastBit) nextState = DONE;
      end
      DONE: begin
        Done      = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sa      <= '0;
      sb      <= '0;
      res     <= '0;
      br      <= 1'b0;
      cnt     <= '0;
      Diff    <= '0;
      BorrowO <= 1'b0;
`ifdef BIT_SERIAL_SUBTRACTOR_OVF_EN
      aMsb     <= 1'b0;
      bMsb     <= 1'b0;
      Overflow <= 1'b0;
`endif
    end else if (state == IDLE) begin
      if (Start) begin
        sa  <= A;
        sb  <= B;
        br  <= BorrowI;
        cnt <= '0;
`ifdef BIT_SERIAL_SUBTRACTOR_OVF_EN
        aMsb <= A[WIDTH-1];
        bMsb <= B[WIDTH-1];
`endif
      end
    end else if (state == RUN) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      res <= {d, res[WIDTH-2:1]};
      br  <= brNext;
      cnt <= cnt + CNT_W'(1);
      if (lastBit) begin
        Diff    <= {d, res};
        BorrowO <= brNext;
`ifdef BIT_SERIAL_SUBTRACTOR_OVF_EN
        Overflow <= (aMsb != bMsb) && (d != aMsb);
`endif
      end
    end
  end

endmodule

// File: doc/bit_serial_subtractor.md
Name: bit_serial_subtractor

Overview:
- Bit-serial WIDTH-bit subtractor: computes Diff = A - B - BorrowI, processing one bit per clock with a single borrow flip-flop.
- Complements the ripple-carry and carry-lookahead adders. Same operand widths (15-bit default), same carry/borrow-in/out convention.
- Used where area matters more than latency, and as a cross-check engine against the parallel adders in two's-complement mode.

Parameters:
- WIDTH, 15, operand and result width in bits (legal range 2..32)
- CNT_W, 5, bit-counter width; must satisfy 2^CNT_W > WIDTH

Ports:
- Clk  input  1  system clock; all state updates on the rising edge
- Reset  input  1  synchronous, active-high reset
- Start  input  1  request; sampled only in IDLE
- A  input  WIDTH  minuend; sampled on the accepting edge only
- B  input  WIDTH  subtrahend; sampled on the accepting edge only
- BorrowI  input  1  borrow-in; sampled on the accepting edge only
- Busy  output  1  high while bits are being processed
- Done  output  1  one-cycle completion pulse
- Diff  output  WIDTH  result register; holds the last completed result
- BorrowO  output  1  final borrow-out; held with Diff

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (synchronous, active-high):
  - State = IDLE.
  - Busy = 0, Done = 0, Diff = 0, BorrowO = 0.
  - Internal shift registers, borrow FF and counter = 0.
  - Reset wins over every other input on the same edge.
- IDLE, Start = 1:
  - Latch A and B into shift registers SA and SB.
  - Borrow FF = BorrowI; counter = 0.
  - Go to RUN; Busy rises after this edge.
- IDLE, Start = 0: hold. Diff and BorrowO keep their previous values.
- RUN, every edge:
  - d = SA[0] ^ SB[0] ^ br.
  - br_next = (~SA[0] & SB[0]) | (~(SA[0] ^ SB[0]) & br).
  - SA and SB shift right by one.
  - d is shifted into the result shift register from the MSB end.
  - counter increments by 1.
- RUN exit:
  - On the edge that processes bit WIDTH-1 (counter == WIDTH-1), go to DONE.
  - On that same edge, Diff <= completed result and BorrowO <= br_next.
- Latency: with the accepting edge numbered 0, RUN occupies edges 1..WIDTH.
  - Busy is high from after edge 0 until after edge WIDTH.
  - Done is high from after edge WIDTH until after edge WIDTH+1.
  - For WIDTH = 15: Done is asserted after edge 15.
- DONE: Done = 1 and Busy = 0 for exactly one cycle, then unconditionally back to IDLE.
- Start is ignored in RUN and DONE. It is not queued; the requester re-asserts it after Done.
- Arithmetic:
  - Result is mod 2^WIDTH.
  - BorrowO = 1 iff A < B + BorrowI as unsigned values.
  - Diff and BorrowO together are bit-exact with A + ~B + ~BorrowI computed on a ripple-carry adder, with BorrowO = ~CarryO.
- Boundaries:
  - A == B with BorrowI = 0 gives 0, BorrowO = 0.
  - 0 - 0 - 1 gives all-ones, BorrowO = 1.
  - All-ones minus all-ones gives 0.
  - Counter wrap cannot occur, because RUN exits at WIDTH-1.
- Reset mid-operation: aborts the operation. Diff and BorrowO clear to 0, and no Done pulse is produced.
- Operand inputs may change freely after the accepting edge with no effect.

Optional Feature:
- Macro: BIT_SERIAL_SUBTRACTOR_OVF_EN.
- Defined:
  - Adds output port Overflow (1 bit), the two's-complement overflow flag.
  - Overflow = (A[WIDTH-1] != B[WIDTH-1]) && (Diff[WIDTH-1] != A[WIDTH-1]), using the latched operand MSBs.
  - Overflow is registered on the same edge as Diff and held with it.
  - Reset value is 0; it also clears on reset mid-operation.
- Undefined: no Overflow port and no MSB latches. All other behaviour is identical.

Test Plan:
- WIDTH = 15; A = 5, B = 3, BorrowI = 0, Start pulse at edge 0 -> Busy high for 15 cycles, Done pulse after edge 15, Diff = 0x0002, BorrowO = 0.
- A = 3, B = 5, BorrowI = 0 -> Diff = 0x7FFE, BorrowO = 1. Diff holds across 10 further idle cycles.
- A = 0, B = 0, BorrowI = 1 -> Diff = 0x7FFF, BorrowO = 1. Then A = 0x7FFF, B = 0x7FFF, BorrowI = 0 -> Diff = 0x0000, BorrowO = 0.
- Start 9 - 4, then assert Start again with 1 - 1 at edge 6 during RUN -> second request ignored. Only one Done, with Diff = 0x0005.
- Start 0x1234 - 0x0034, assert Reset at edge 7 -> after reset Busy = 0, Done never pulses, Diff = 0, BorrowO = 0. A new Start of 10 - 1 completes normally with Diff = 9.
- With BIT_SERIAL_SUBTRACTOR_OVF_EN: 0x4000 - 0x0001 -> Diff = 0x3FFF, Overflow = 1, BorrowO = 0. 0x0005 - 0x0003 -> Overflow = 0.
